// File: rtl/cpu_seq_pkg.sv
// Shared types for the CPU control sequencer: FSM states, instruction classes
// and the opcode values the class decoder recognises.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } seq_state_e;

  typedef enum logic [2:0] {
    C_ALU, C_CMP, C_LD, C_ST, C_JMP, C_CALL, C_ILL
  } op_class_e;

  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_MVHI = 4'h6;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JN   = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hC;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface cpu_sequencer_if;
  logic [4:0]  i_opcode;
  logic        i_mem_waitrequest;
  logic        i_halt_req;
  logic        i_step;
  logic        o_ir_load;
  logic        o_mdr_load;
  logic        o_pc_en;
  logic        o_reg_we;
  logic        o_nz_en;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic        o_mem_sel;
  logic        o_halted;
  logic        o_illegal;
  logic [15:0] o_retired;
  logic [15:0] o_stalls;

  modport master (
    input  i_opcode, i_mem_waitrequest, i_halt_req, i_step,
    output o_ir_load, o_mdr_load, o_pc_en, o_reg_we, o_nz_en,
           o_mem_rd, o_mem_wr, o_mem_sel, o_halted, o_illegal,
           o_retired, o_stalls
  );

  modport slave (
    output i_opcode, i_mem_waitrequest, i_halt_req, i_step,
    input  o_ir_load, o_mdr_load, o_pc_en, o_reg_we, o_nz_en,
           o_mem_rd, o_mem_wr, o_mem_sel, o_halted, o_illegal,
           o_retired, o_stalls
  );
endinterface

// File: rtl/cpu_seq_class_decode.sv
// Maps the low four opcode bits onto an instruction class; anything
// not listed decodes as illegal.
module cpu_seq_class_decode
  import cpu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = C_ILL;
    case (opcode)
      OP_MV, OP_ADD, OP_SUB, OP_MVHI: op_class = C_ALU;
      OP_CMP:                         op_class = C_CMP;
      OP_LD:                          op_class = C_LD;
      OP_ST:                          op_class = C_ST;
      OP_J, OP_JZ, OP_JN:             op_class = C_JMP;
      OP_CALL:                        op_class = C_CALL;
      default:                        op_class = C_ILL;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer with memory stall and debug halt/step.
// CPU_SEQ_PERF_EN adds the retired-instruction and wait-state counters.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter bit RESET_HALT = 1'b0
) (
  input logic             clk,
  input logic             reset,
  cpu_sequencer_if.master bus
);

  seq_state_e state;
  logic       step_pend;
  op_class_e  cls;
  logic       is_addsub;
  logic       wait_req;
  logic       unused_op4;
  seq_state_e retire_state;

  logic ir_load, mdr_load, pc_en, reg_we, nz_en;
  logic mem_rd, mem_wr, mem_sel, halted, illegal;

  cpu_seq_class_decode u_dec (
    .opcode   (bus.i_opcode[3:0]),
    .op_class (cls)
  );

  assign unused_op4   = bus.i_opcode[4];
  assign wait_req     = bus.i_mem_waitrequest;
  assign is_addsub    = (bus.i_opcode[3:0] == OP_ADD) || (bus.i_opcode[3:0] == OP_SUB);
  // A pending single step forces a return to HALT even with halt_req dropped.
  assign retire_state = (bus.i_halt_req || step_pend) ? S_HALT : S_FETCH;

  always_comb begin
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    pc_en    = 1'b0;
    reg_we   = 1'b0;
    nz_en    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_sel  = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = !wait_req;
      end
      S_EXEC: begin
        case (cls)
          C_ALU:  begin reg_we = 1'b1; nz_en = is_addsub; pc_en = 1'b1; end
          C_CMP:  begin nz_en = 1'b1; pc_en = 1'b1; end
          C_JMP:  pc_en = 1'b1;
          C_CALL: begin reg_we = 1'b1; pc_en = 1'b1; end
          C_ILL:  begin pc_en = 1'b1; illegal = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_sel  = 1'b1;
        mem_rd   = (cls == C_LD);
        mem_wr   = (cls == C_ST);
        mdr_load = (cls == C_LD) && !wait_req;
        pc_en    = (cls == C_ST) && !wait_req;
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_en  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RST;
      step_pend <= 1'b0;
    end else begin
      case (state)
        S_RST:    state <= RESET_HALT ? S_HALT : S_FETCH;
        S_FETCH:  if (!wait_req) state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (cls == C_LD || cls == C_ST) begin
            state <= S_MEM;
          end else begin
            state     <= retire_state;
            step_pend <= 1'b0;
          end
        end
        S_MEM: begin
          if (!wait_req) begin
            if (cls == C_LD) begin
              state <= S_WB;
            end else begin
              state     <= retire_state;
              step_pend <= 1'b0;
            end
          end
        end
        S_WB: begin
          state     <= retire_state;
          step_pend <= 1'b0;
        end
        S_HALT: begin
          if (bus.i_step) begin
            step_pend <= 1'b1;
            state     <= S_FETCH;
          end else if (!bus.i_halt_req) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

  assign bus.o_ir_load  = ir_load;
  assign bus.o_mdr_load = mdr_load;
  assign bus.o_pc_en    = pc_en;
  assign bus.o_reg_we   = reg_we;
  assign bus.o_nz_en    = nz_en;
  assign bus.o_mem_rd   = mem_rd;
  assign bus.o_mem_wr   = mem_wr;
  assign bus.o_mem_sel  = mem_sel;
  assign bus.o_halted   = halted;
  assign bus.o_illegal  = illegal;

`ifdef CPU_SEQ_PERF_EN
  logic [15:0] retired_q;
  logic [15:0] stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 16'd0;
      stalls_q  <= 16'd0;
    end else begin
      if (pc_en) retired_q <= retired_q + 16'd1;
      if ((state == S_FETCH || state == S_MEM) && wait_req) stalls_q <= stalls_q + 16'd1;
    end
  end

  assign bus.o_retired = retired_q;
  assign bus.o_stalls  = stalls_q;
`else
  assign bus.o_retired = 16'd0;
  assign bus.o_stalls  = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle strobe vectors from
// stimulus tables go through a scoreboard queue and are compared at negedge.
module tb_cpu_sequencer;

  localparam logic [9:0] IR  = 10'h200;
  localparam logic [9:0] MDR = 10'h100;
  localparam logic [9:0] PC  = 10'h080;
  localparam logic [9:0] WE  = 10'h040;
  localparam logic [9:0] NZ  = 10'h020;
  localparam logic [9:0] RD  = 10'h010;
  localparam logic [9:0] WR  = 10'h008;
  localparam logic [9:0] SEL = 10'h004;
  localparam logic [9:0] HLT = 10'h002;
  localparam logic [9:0] ILL = 10'h001;

`ifdef CPU_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] op;
    logic       wt;
    logic       hr;
    logic       st;
    logic [9:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] ret_exp = 16'd0;
  logic [15:0] stall_exp = 16'd0;
  logic [9:0]  sb[$];

  always #5 clk = ~clk;

  cpu_sequencer_if bus ();
  cpu_sequencer_if bus_h ();

  cpu_sequencer #(.RESET_HALT(1'b0)) dut   (.clk(clk), .reset(reset), .bus(bus));
  cpu_sequencer #(.RESET_HALT(1'b1)) dut_h (.clk(clk), .reset(reset), .bus(bus_h));

  logic [9:0] obs, obs_h;
  assign obs   = {bus.o_ir_load, bus.o_mdr_load, bus.o_pc_en, bus.o_reg_we, bus.o_nz_en,
                  bus.o_mem_rd, bus.o_mem_wr, bus.o_mem_sel, bus.o_halted, bus.o_illegal};
  assign obs_h = {bus_h.o_ir_load, bus_h.o_mdr_load, bus_h.o_pc_en, bus_h.o_reg_we, bus_h.o_nz_en,
                  bus_h.o_mem_rd, bus_h.o_mem_wr, bus_h.o_mem_sel, bus_h.o_halted, bus_h.o_illegal};

  function automatic row_t mk(input logic [4:0] op, input logic wt, input logic hr,
                              input logic st, input logic [9:0] exp);
    row_t r;
    r.op = op; r.wt = wt; r.hr = hr; r.st = st; r.exp = exp;
    return r;
  endfunction

  // Apply one cycle of stimulus, queue its expected strobes, move to the sample point.
  task automatic drive(input row_t r);
    bus.i_opcode          = r.op;
    bus.i_mem_waitrequest = r.wt;
    bus.i_halt_req        = r.hr;
    bus.i_step            = r.st;
    sb.push_back(r.exp);
    @(negedge clk);
  endtask

  // Finish the cycle and account for the counter updates it should cause.
  task automatic advance(input row_t r);
    if (PERF) begin
      if ((r.exp & PC) != 10'd0) ret_exp = ret_exp + 16'd1;
      if (r.wt && ((r.exp & (RD | WR)) != 10'd0)) stall_exp = stall_exp + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    bus.i_opcode = 5'h00; bus.i_mem_waitrequest = 1'b0; bus.i_halt_req = 1'b0; bus.i_step = 1'b0;
    bus_h.i_opcode = 5'h01; bus_h.i_mem_waitrequest = 1'b0; bus_h.i_halt_req = 1'b1; bus_h.i_step = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== 10'd0 || bus.o_retired !== 16'd0 || bus.o_stalls !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_hold strobes=%b ret=%0d stl=%0d expected 0", obs, bus.o_retired, bus.o_stalls);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ret_exp = 16'd0; stall_exp = 16'd0;
    sb.push_back(10'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_rst_cycle strobes=%b expected %b", obs, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_counters(input string name);
    n_checks++;
    if (bus.o_retired !== ret_exp || bus.o_stalls !== stall_exp) begin
      n_fail++;
      $display("FAIL %s_counters ret=%0d stl=%0d expected ret=%0d stl=%0d",
               name, bus.o_retired, bus.o_stalls, ret_exp, stall_exp);
    end
  endtask

  task automatic test_add();
    row_t t[$];
    logic [9:0] e;
    t.push_back(mk(5'h01, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h01, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h01, 0, 0, 0, WE | NZ | PC));
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL add[%0d] strobes=%b expected %b", i, obs, e); end
      advance(t[i]);
    end
    check_counters("add");
  endtask

  task automatic test_ld_wait();
    row_t t[$];
    logic [9:0] e;
    t.push_back(mk(5'h04, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h04, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h04, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h04, 1, 0, 0, RD | SEL));
    t.push_back(mk(5'h04, 1, 0, 0, RD | SEL));
    t.push_back(mk(5'h04, 0, 0, 0, MDR | RD | SEL));
    t.push_back(mk(5'h04, 0, 0, 0, WE | PC));
    t.push_back(mk(5'h00, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h00, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h00, 0, 0, 0, WE | PC));
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL ld[%0d] strobes=%b expected %b", i, obs, e); end
      advance(t[i]);
    end
    check_counters("ld");
  endtask

  task automatic test_st();
    row_t t[$];
    logic [9:0] e;
    t.push_back(mk(5'h05, 1, 0, 0, RD));
    t.push_back(mk(5'h05, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h05, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h05, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h05, 0, 0, 0, WR | SEL | PC));
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL st[%0d] strobes=%b expected %b", i, obs, e); end
      advance(t[i]);
    end
    check_counters("st");
  endtask

  task automatic test_halt_step();
    row_t t[$];
    logic [9:0] e;
    // halt requested mid-load: the load completes first
    t.push_back(mk(5'h04, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h04, 0, 1, 0, 10'd0));
    t.push_back(mk(5'h04, 0, 1, 0, 10'd0));
    t.push_back(mk(5'h04, 0, 1, 0, MDR | RD | SEL));
    t.push_back(mk(5'h04, 0, 1, 0, WE | PC));
    t.push_back(mk(5'h01, 0, 1, 0, HLT));
    t.push_back(mk(5'h01, 0, 1, 0, HLT));
    t.push_back(mk(5'h01, 0, 1, 1, HLT));
    t.push_back(mk(5'h01, 0, 1, 0, IR | RD));
    t.push_back(mk(5'h01, 0, 1, 0, 10'd0));
    t.push_back(mk(5'h01, 0, 1, 0, WE | NZ | PC));
    t.push_back(mk(5'h03, 0, 1, 0, HLT));
    // step in the same cycle halt_req drops: one instruction, then HALT again
    t.push_back(mk(5'h03, 0, 0, 1, HLT));
    t.push_back(mk(5'h03, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h03, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h03, 0, 0, 0, NZ | PC));
    t.push_back(mk(5'h01, 0, 0, 0, HLT));
    t.push_back(mk(5'h01, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h01, 0, 0, 1, 10'd0));
    t.push_back(mk(5'h01, 0, 0, 0, WE | NZ | PC));
    t.push_back(mk(5'h01, 0, 0, 0, IR | RD));
    t.push_back(mk(5'h01, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h01, 0, 0, 0, WE | NZ | PC));
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL halt[%0d] strobes=%b expected %b", i, obs, e); end
      advance(t[i]);
    end
    check_counters("halt");
  endtask

  task automatic test_classes_and_reset();
    row_t t[$];
    logic [9:0] e;
    logic [4:0] ops[8];
    logic [9:0] ex[8];
    ops = '{5'h0F, 5'h08, 5'h0C, 5'h06, 5'h16, 5'h0A, 5'h07, 5'h02};
    ex  = '{PC | ILL, PC, WE | PC, WE | PC, WE | PC, PC, PC | ILL, WE | NZ | PC};
    for (int k = 0; k < 8; k++) begin
      t.push_back(mk(ops[k], 0, 0, 0, IR | RD));
      t.push_back(mk(ops[k], 0, 0, 0, 10'd0));
      t.push_back(mk(ops[k], 0, 0, 0, ex[k]));
    end
    t.push_back(mk(5'h00, 1, 0, 0, RD));
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL class[%0d] op=%h strobes=%b expected %b", i, t[i].op, obs, e); end
      advance(t[i]);
    end
    // still stalled in FETCH; reset must clear everything without a clock edge
    #2;
    n_checks++;
    if (obs !== RD) begin n_fail++; $display("FAIL stall_hold strobes=%b expected %b", obs, RD); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'd0 || bus.o_retired !== 16'd0 || bus.o_stalls !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset strobes=%b ret=%0d stl=%0d expected 0", obs, bus.o_retired, bus.o_stalls);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ret_exp = 16'd0; stall_exp = 16'd0;
    t.delete();
    t.push_back(mk(5'h00, 0, 0, 0, 10'd0));
    t.push_back(mk(5'h00, 0, 0, 0, IR | RD));
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL post_reset[%0d] strobes=%b expected %b", i, obs, e); end
      advance(t[i]);
    end
  endtask

  task automatic test_reset_halt();
    logic [9:0] e;
    logic       hr[7];
    logic [9:0] ex[7];
    hr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex = '{10'd0, HLT, HLT, HLT, HLT, IR | RD, 10'd0};
    bus_h.i_halt_req = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus_h.i_halt_req = hr[k];
      sb.push_back(ex[k]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (obs_h !== e) begin n_fail++; $display("FAIL reset_halt[%0d] strobes=%b expected %b", k, obs_h, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_add();
    test_ld_wait();
    test_st();
    test_halt_step();
    test_classes_and_reset();
    test_reset_halt();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain left=%0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
